// File: rtl/game_pkg.sv
// Shared game types and default constants for the collision event scorer.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        COOLDOWN  = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

    localparam int DEF_SCORE_W         = 16;
    localparam int DEF_POINTS_PER_KILL = 10;
    localparam int DEF_INIT_LIVES      = 3;
    localparam int DEF_COOLDOWN_FRAMES = 30;

    localparam int LIVES_W = 4;
    localparam int CD_W    = 8;

endpackage

// File: rtl/frame_single_pulse.sv
// Flags the first cycle per frame in which a collision input is high.
// The start-of-frame cycle itself belongs to the new frame.
module frame_single_pulse (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic collision,
    output logic pulse
);

    logic seen;

    assign pulse = collision && (startOfFrame || !seen);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            seen <= 1'b0;
        end else if (startOfFrame) begin
            seen <= collision;
        end else if (collision) begin
            seen <= 1'b1;
        end
    end

endmodule

// File: rtl/collision_event_scorer.sv
// Turns per-pixel collisions into per-frame game events, score and lives.
// Define SCORE_SATURATE_EN to clamp the score instead of wrapping it.
module collision_event_scorer
    import game_pkg::*;
#(
    parameter int SCORE_W         = DEF_SCORE_W,
    parameter int POINTS_PER_KILL = DEF_POINTS_PER_KILL,
    parameter int INIT_LIVES      = DEF_INIT_LIVES,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               ShotBoxCollision,
    input  logic               TowerEnemyHUCollision,
    input  logic               ShotEnemyCollision,
    input  logic               restart,
    output logic               ShotBoxPulse,
    output logic               TowerHitPulse,
    output logic               EnemyKillPulse,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         lives,
    output logic               invulnerable,
    output logic               gameOver
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
    localparam logic [CD_W-1:0]    CD_INIT    = CD_W'(COOLDOWN_FRAMES);

    game_state_t        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d, score_inc;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [CD_W-1:0]    cd_q, cd_d;
    logic               shot_p_d, tower_p_d, kill_p_d;
    logic               shot_ev, tower_ev, kill_ev;
    logic               restart_ok, flag_resetN;

    assign restart_ok  = (state_q == GAME_OVER) && restart;
    // Edge detectors share the synchronous reset path so a restart clears their flags.
    assign flag_resetN = resetN && !restart_ok;

    frame_single_pulse u_shot_box (
        .clk          (clk),
        .resetN       (flag_resetN),
        .startOfFrame (startOfFrame),
        .collision    (ShotBoxCollision),
        .pulse        (shot_ev)
    );

    frame_single_pulse u_tower (
        .clk          (clk),
        .resetN       (flag_resetN),
        .startOfFrame (startOfFrame),
        .collision    (TowerEnemyHUCollision),
        .pulse        (tower_ev)
    );

    frame_single_pulse u_kill (
        .clk          (clk),
        .resetN       (flag_resetN),
        .startOfFrame (startOfFrame),
        .collision    (ShotEnemyCollision),
        .pulse        (kill_ev)
    );

`ifdef SCORE_SATURATE_EN
    localparam logic [SCORE_W:0] POINTS_EXT = (SCORE_W + 1)'(POINTS_PER_KILL);
    logic [SCORE_W:0] score_sum;
    assign score_sum = {1'b0, score_q} + POINTS_EXT;
    assign score_inc = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
`else
    localparam logic [SCORE_W-1:0] POINTS_VAL = SCORE_W'(POINTS_PER_KILL);
    assign score_inc = score_q + POINTS_VAL;
`endif

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        lives_d   = lives_q;
        cd_d      = cd_q;
        shot_p_d  = 1'b0;
        tower_p_d = 1'b0;
        kill_p_d  = 1'b0;
        case (state_q)
            PLAY: begin
                shot_p_d = shot_ev;
                if (kill_ev) begin
                    kill_p_d = 1'b1;
                    score_d  = score_inc;
                end
                if (tower_ev) begin
                    tower_p_d = 1'b1;
                    lives_d   = lives_q - 4'd1;
                    if (lives_q <= 4'd1) begin
                        state_d = GAME_OVER;
                    end else begin
                        state_d = COOLDOWN;
                        cd_d    = CD_INIT;
                    end
                end
            end
            COOLDOWN: begin
                shot_p_d = shot_ev;
                if (kill_ev) begin
                    kill_p_d = 1'b1;
                    score_d  = score_inc;
                end
                if (startOfFrame) begin
                    if (cd_q <= 8'd1) begin
                        cd_d    = '0;
                        state_d = PLAY;
                    end else begin
                        cd_d = cd_q - 8'd1;
                    end
                end
            end
            GAME_OVER: begin
                if (restart) begin
                    state_d = PLAY;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                    cd_d    = '0;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q        <= PLAY;
            score_q        <= '0;
            lives_q        <= LIVES_INIT;
            cd_q           <= '0;
            ShotBoxPulse   <= 1'b0;
            TowerHitPulse  <= 1'b0;
            EnemyKillPulse <= 1'b0;
        end else begin
            state_q        <= state_d;
            score_q        <= score_d;
            lives_q        <= lives_d;
            cd_q           <= cd_d;
            ShotBoxPulse   <= shot_p_d;
            TowerHitPulse  <= tower_p_d;
            EnemyKillPulse <= kill_p_d;
        end
    end

    assign score        = score_q;
    assign lives        = lives_q;
    assign invulnerable = (state_q == COOLDOWN);
    assign gameOver     = (state_q == GAME_OVER);

endmodule
